ball_motion: RTL

BALL_MOTION -- requirements
Module: ball_motion

---
 rtl/ball_pkg.sv | 62 ++++++
 rtl/frame_tick_gen.sv | 41 ++++
 rtl/ball_motion.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ball_pkg.sv
// Shared constants for the bouncing-ball block: screen geometry, respawn point,
// FSM encoding, colours and the per-axis motion helpers.
package ball_pkg;

  localparam int unsigned SCREEN_W  = 160;
  localparam int unsigned SCREEN_H  = 120;
  localparam int unsigned BALL_SIZE = 4;
  localparam int unsigned START_X   = 78;
  localparam int unsigned START_Y   = 100;

  localparam logic [2:0] ST_INIT      = 3'd0;
  localparam logic [2:0] ST_WAIT_TICK = 3'd1;
  localparam logic [2:0] ST_ERASE     = 3'd2;
  localparam logic [2:0] ST_UPDATE    = 3'd3;
  localparam logic [2:0] ST_DRAW      = 3'd4;

  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_WHITE = 3'b111;

  // inc = 1 means moving towards larger coordinates (right / down)
  typedef struct packed {
    logic [9:0] pos;
    logic       inc;
  } axis_t;

  // One motion step on one axis: clamp at 0 or hi_lim and bounce.
  function automatic axis_t axis_step(input logic [9:0] pos, input logic inc,
                                      input logic [10:0] speed, input logic [10:0] hi_lim);
    axis_t       r;
    logic [10:0] p;
    logic [10:0] sum;
    p     = {1'b0, pos};
    sum   = 11'd0;
    r.pos = pos;
    r.inc = inc;
    if (inc) begin
      if (p + speed > hi_lim) begin
        r.pos = hi_lim[9:0];
        r.inc = 1'b0;
      end else begin
        sum   = p + speed;
        r.pos = sum[9:0];
      end
    end else begin
      if (p < speed) begin
        r.pos = 10'd0;
        r.inc = 1'b1;
      end else begin
        sum   = p - speed;
        r.pos = sum[9:0];
      end
    end
    return r;
  endfunction

  // True when a step towards larger coordinates would cross hi_lim.
  function automatic logic axis_over(input logic [9:0] pos, input logic inc,
                                     input logic [10:0] speed, input logic [10:0] hi_lim);
    return inc && (({1'b0, pos} + speed) > hi_lim);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame divider: counts 0..FRAME_CYCLES-1 and emits a one-cycle
// tick in the cycle following the wrap.
module frame_tick_gen #(
  parameter int unsigned FRAME_CYCLES = 833333
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int unsigned CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // next count and wrap detection
  always_comb begin
    if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
      tick_d = 1'b0;
    end
  end

  // divider state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/ball_motion.sv
// Ball controller: once per accepted frame tick it erases the ball, applies
// collision and wall rules, and redraws it through a handshaked square drawer.
module ball_motion #(
  parameter int unsigned SCREEN_W     = ball_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H     = ball_pkg::SCREEN_H,
  parameter int unsigned SIZE         = ball_pkg::BALL_SIZE,
  parameter int unsigned SPEED        = 1,
  parameter int unsigned FRAME_CYCLES = 833333,
  parameter int unsigned START_X      = ball_pkg::START_X,
  parameter int unsigned START_Y      = ball_pkg::START_Y
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       paddle_hit,
  input  logic       brick_hit_x,
  input  logic       brick_hit_y,
  input  logic       draw_done,
  output logic       draw_go,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] size,
  output logic [2:0] draw_color,
  output logic       ball_lost
);

  import ball_pkg::*;

  localparam logic [10:0] X_LIM   = 11'(SCREEN_W - SIZE);
  localparam logic [10:0] Y_LIM   = 11'(SCREEN_H - SIZE);
  localparam logic [10:0] SPEED_W = 11'(SPEED);
  localparam logic [9:0]  X0      = 10'(START_X);
  localparam logic [9:0]  Y0      = 10'(START_Y);

  logic [2:0] state_q, state_d;
  logic       init_go_q, init_go_d;
  logic       pending_q, pending_d;
  logic       hit_x_q, hit_x_d, hit_y_q, hit_y_d, pad_q, pad_d;
  logic       dx_q, dx_d, dy_q, dy_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       go_q, go_d, lost_q, lost_d;
  logic [2:0] color_q, color_d;

  logic  tick_s, consume_s, in_update_s;
  logic  dx_pre_s, dy_pre_s, over_y_s;
  axis_t ax_s, ay_s;

  frame_tick_gen #(.FRAME_CYCLES(FRAME_CYCLES)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .tick   (tick_s)
  );

  // collisions first (paddle beats brick on y), then walls on the result
  always_comb begin
    dx_pre_s = dx_q ^ (hit_x_q | brick_hit_x);
    dy_pre_s = (pad_q | paddle_hit) ? 1'b0 : (dy_q ^ (hit_y_q | brick_hit_y));
    ax_s     = axis_step(x_q, dx_pre_s, SPEED_W, X_LIM);
    ay_s     = axis_step(y_q, dy_pre_s, SPEED_W, Y_LIM);
    over_y_s = axis_over(y_q, dy_pre_s, SPEED_W, Y_LIM);
  end

  // pending tick and sticky collision flags
  always_comb begin
    consume_s   = (state_q == ST_WAIT_TICK) && pending_q;
    in_update_s = (state_q == ST_UPDATE);
    if (consume_s) begin
      pending_d = 1'b0;
    end else if (tick_s && enable) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
    hit_x_d = in_update_s ? 1'b0 : (hit_x_q | brick_hit_x);
    hit_y_d = in_update_s ? 1'b0 : (hit_y_q | brick_hit_y);
    pad_d   = in_update_s ? 1'b0 : (pad_q | paddle_hit);
  end

  // frame sequencer; draw_go is raised on the edge that enters a drawing state
  always_comb begin
    state_d   = state_q;
    init_go_d = init_go_q;
    go_d      = 1'b0;
    lost_d    = 1'b0;
    color_d   = color_q;
    x_d       = x_q;
    y_d       = y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    case (state_q)
      ST_INIT: begin
        if (!init_go_q) begin
          go_d      = 1'b1;
          init_go_d = 1'b1;
          color_d   = COLOR_WHITE;
        end else if (draw_done) begin
          state_d = ST_WAIT_TICK;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_WAIT_TICK: begin
        if (pending_q) begin
          state_d = ST_ERASE;
          go_d    = 1'b1;
          color_d = COLOR_BLACK;
        end else begin
          state_d = ST_WAIT_TICK;
        end
      end
      ST_ERASE: begin
        if (draw_done) begin
          state_d = ST_UPDATE;
        end else begin
          state_d = ST_ERASE;
        end
      end
      ST_UPDATE: begin
        state_d = ST_DRAW;
        go_d    = 1'b1;
        color_d = COLOR_WHITE;
        dx_d    = ax_s.inc;
        // falling off the bottom respawns the ball heading up
        if (over_y_s) begin
          x_d    = X0;
          y_d    = Y0;
          dy_d   = 1'b0;
          lost_d = 1'b1;
        end else begin
          x_d  = ax_s.pos;
          y_d  = ay_s.pos;
          dy_d = ay_s.inc;
        end
      end
      ST_DRAW: begin
        if (draw_done) begin
          state_d = ST_WAIT_TICK;
        end else begin
          state_d = ST_DRAW;
        end
      end
      default: begin
        state_d   = ST_INIT;
        init_go_d = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_INIT;
      init_go_q <= 1'b0;
      pending_q <= 1'b0;
      hit_x_q   <= 1'b0;
      hit_y_q   <= 1'b0;
      pad_q     <= 1'b0;
      dx_q      <= 1'b1;
      dy_q      <= 1'b0;
      x_q       <= X0;
      y_q       <= Y0;
      go_q      <= 1'b0;
      lost_q    <= 1'b0;
      color_q   <= COLOR_BLACK;
    end else begin
      state_q   <= state_d;
      init_go_q <= init_go_d;
      pending_q <= pending_d;
      hit_x_q   <= hit_x_d;
      hit_y_q   <= hit_y_d;
      pad_q     <= pad_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      x_q       <= x_d;
      y_q       <= y_d;
      go_q      <= go_d;
      lost_q    <= lost_d;
      color_q   <= color_d;
    end
  end

  assign draw_go    = go_q;
  assign ball_x     = x_q;
  assign ball_y     = y_q;
  assign size       = 10'(SIZE);
  assign draw_color = color_q;
  assign ball_lost  = lost_q;

endmodule
